// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_pkg: shared FSM encoding, bus field widths and default error read data
package mem_bus_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int STRB_W = 4;
   localparam logic [DATA_W-1:0] ERR_RDATA_DEF = 32'hdead_beef;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: bundled requester/slave bus signals shared with the arbiter
interface mem_bus_arbiter_if
   import mem_bus_pkg::*;
#(
   parameter int NR_MASTERS = 2,
   localparam int GW = NR_MASTERS > 1 ? $clog2(NR_MASTERS) : 1
);
   logic [NR_MASTERS-1:0]        m_valid;
   logic [NR_MASTERS-1:0]        m_instr;
   logic [ADDR_W*NR_MASTERS-1:0] m_addr;
   logic [DATA_W*NR_MASTERS-1:0] m_wdata;
   logic [STRB_W*NR_MASTERS-1:0] m_wstrb;
   logic [NR_MASTERS-1:0]        m_ready;
   logic [DATA_W-1:0]            m_rdata;
   logic                         s_valid;
   logic                         s_instr;
   logic [ADDR_W-1:0]            s_addr;
   logic [DATA_W-1:0]            s_wdata;
   logic [STRB_W-1:0]            s_wstrb;
   logic                         s_ready;
   logic [DATA_W-1:0]            s_rdata;
   logic [GW-1:0]                grant_id;
   logic                         timeout_err;
   // master: the requesters plus the memory slave; slave: the arbiter itself
   modport master (
      output m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
      input  m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb, grant_id, timeout_err
   );
   modport slave (
      input  m_valid, m_instr, m_addr, m_wdata, m_wstrb, s_ready, s_rdata,
      output m_ready, m_rdata, s_valid, s_instr, s_addr, s_wdata, s_wstrb, grant_id, timeout_err
   );
endinterface

// File: rtl/mem_bus_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker, first request after i_ptr with wrap-around
module rr_pick #(
   parameter int N = 2,
   localparam int GW = N > 1 ? $clog2(N) : 1
) (
   input  logic [N-1:0]  i_req,
   input  logic [GW-1:0] i_ptr,
   output logic [GW-1:0] o_win,
   output logic          o_any
);
   always_comb begin
      int   j;
      logic found;
      o_win = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 1; k <= N; k++) begin
         j = (int'(i_ptr) + k) % N;
         if (!found && i_req[j]) begin
            o_win = GW'(j);
            found = 1'b1;
         end
      end
   end
   assign o_any = |i_req;
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin whole-transaction arbiter for a valid/ready memory bus with watchdog
module mem_bus_arbiter
   import mem_bus_pkg::*;
#(
   parameter int NR_MASTERS = 2,
   parameter int TIMEOUT_CYCLES = 256,
   parameter logic [DATA_W-1:0] ERR_RDATA = ERR_RDATA_DEF,
   localparam int GW = NR_MASTERS > 1 ? $clog2(NR_MASTERS) : 1,
   localparam int WW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1
) (
   input logic clk,
   input logic reset,
   mem_bus_arbiter_if.slave bus
);
   state_t        r_state;
   logic [GW-1:0] r_gid;
   logic [GW-1:0] r_ptr;
   logic [WW-1:0] r_wd;
   logic [GW-1:0] w_win;
   logic          w_any;
   logic          w_busy;
   logic          w_gvalid;
   logic          w_drop;
   logic          w_ok;
   logic          w_to;
   rr_pick #(.N(NR_MASTERS)) u_pick (
      .i_req(bus.m_valid),
      .i_ptr(r_ptr),
      .o_win(w_win),
      .o_any(w_any)
   );
   assign w_busy   = r_state == BUSY;
   assign w_gvalid = bus.m_valid[r_gid];
   assign w_drop   = w_busy && !w_gvalid;
   assign w_ok     = w_busy && w_gvalid && bus.s_ready;
   // s_ready on the last watchdog cycle wins over the timeout
   assign w_to     = w_busy && w_gvalid && !bus.s_ready && TIMEOUT_CYCLES != 0 && r_wd == WW'(TIMEOUT_CYCLES - 1);
   assign bus.s_valid     = w_busy && w_gvalid && !w_to;
   assign bus.s_instr     = bus.m_instr[r_gid];
   assign bus.s_addr      = bus.m_addr[ADDR_W*r_gid +: ADDR_W];
   assign bus.s_wdata     = bus.m_wdata[DATA_W*r_gid +: DATA_W];
   assign bus.s_wstrb     = bus.m_wstrb[STRB_W*r_gid +: STRB_W];
   assign bus.m_ready     = (w_ok || w_to) ? NR_MASTERS'(1) << r_gid : '0;
   assign bus.m_rdata     = w_ok ? bus.s_rdata : w_to ? ERR_RDATA : '0;
   assign bus.timeout_err = w_to;
   assign bus.grant_id    = r_gid;
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_gid   <= '0;
         r_ptr   <= GW'(NR_MASTERS - 1);
         r_wd    <= '0;
      end else begin
         case (r_state)
            IDLE: if (w_any) begin
               r_gid   <= w_win;
               r_wd    <= '0;
               r_state <= BUSY;
            end
            BUSY: if (w_drop) r_state <= IDLE;
            else if (w_ok || w_to) begin
               r_ptr   <= r_gid;
               r_state <= DONE;
            end else r_wd <= r_wd + WW'(1);
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter with two masters and an 8-cycle watchdog
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int checks = 0;
   int errors = 0;
   always #5 clk = ~clk;
   mem_bus_arbiter_if #(.NR_MASTERS(2)) bus ();
   mem_bus_arbiter #(.NR_MASTERS(2), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #2;
   endtask
   initial begin
      bus.m_valid = '0;
      bus.m_instr = '0;
      bus.m_addr  = '0;
      bus.m_wdata = '0;
      bus.m_wstrb = '0;
      bus.s_ready = 1'b0;
      bus.s_rdata = '0;
      tick;
      tick;
      reset = 1'b0;
      #1;
      chk("rst_svalid", bus.s_valid, 0);
      chk("rst_mready", bus.m_ready, 0);
      chk("rst_grant", bus.grant_id, 0);
      chk("rst_timeout", bus.timeout_err, 0);
      chk("rst_rdata", bus.m_rdata, 0);
      // single read from master 0
      bus.m_valid = 2'b01;
      bus.m_instr = 2'b01;
      bus.m_addr[31:0] = 32'h100;
      bus.s_rdata = 32'h1234_5678;
      #1;
      chk("t1_idle_svalid", bus.s_valid, 0);
      tick;
      #1;
      chk("t1_busy_svalid", bus.s_valid, 1);
      chk("t1_saddr", bus.s_addr, 32'h100);
      chk("t1_sinstr", bus.s_instr, 1);
      chk("t1_swstrb", bus.s_wstrb, 0);
      chk("t1_grant", bus.grant_id, 0);
      chk("t1_wait_mready", bus.m_ready, 0);
      chk("t1_wait_rdata", bus.m_rdata, 0);
      tick;
      bus.s_ready = 1'b1;
      #1;
      chk("t1_mready", bus.m_ready, 2'b01);
      chk("t1_rdata", bus.m_rdata, 32'h1234_5678);
      chk("t1_no_timeout", bus.timeout_err, 0);
      tick;
      bus.s_ready = 1'b0;
      bus.m_valid = 2'b00;
      #1;
      chk("t1_done_svalid", bus.s_valid, 0);
      chk("t1_done_mready", bus.m_ready, 0);
      chk("t1_done_rdata", bus.m_rdata, 0);
      tick;
      #1;
      chk("t1_idle2_svalid", bus.s_valid, 0);
      // fresh arbitration: continuous requests from both masters alternate 0,1,...
      reset = 1'b1;
      tick;
      reset = 1'b0;
      bus.m_instr = 2'b00;
      bus.m_addr  = {32'h300, 32'h200};
      bus.m_wstrb = {4'hf, 4'h0};
      bus.m_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         tick;
         bus.s_ready = 1'b1;
         #1;
         chk("rr_grant", bus.grant_id, k % 2);
         chk("rr_saddr", bus.s_addr, (k % 2) ? 32'h300 : 32'h200);
         chk("rr_swstrb", bus.s_wstrb, (k % 2) ? 4'hf : 4'h0);
         chk("rr_mready", bus.m_ready, (k % 2) ? 2'b10 : 2'b01);
         tick;
         bus.s_ready = 1'b0;
         #1;
         chk("rr_done_svalid", bus.s_valid, 0);
         chk("rr_done_mready", bus.m_ready, 0);
         tick;
      end
      // write from master 1 only
      bus.m_valid = 2'b10;
      bus.m_addr[63:32]  = 32'h40;
      bus.m_wdata[63:32] = 32'haabb_ccdd;
      bus.m_wstrb[7:4]   = 4'b0011;
      tick;
      #1;
      chk("wr_grant", bus.grant_id, 1);
      chk("wr_svalid", bus.s_valid, 1);
      chk("wr_saddr", bus.s_addr, 32'h40);
      chk("wr_swdata", bus.s_wdata, 32'haabb_ccdd);
      chk("wr_swstrb", bus.s_wstrb, 4'b0011);
      bus.s_ready = 1'b1;
      #1;
      chk("wr_mready", bus.m_ready, 2'b10);
      tick;
      bus.s_ready = 1'b0;
      bus.m_valid = 2'b00;
      tick;
      // watchdog: slave never answers
      bus.m_valid = 2'b01;
      bus.m_addr[31:0] = 32'h500;
      bus.s_rdata = 32'h0;
      tick;
      #1;
      chk("to_grant", bus.grant_id, 0);
      chk("to_first_svalid", bus.s_valid, 1);
      for (int k = 0; k < 6; k++) begin
         tick;
         #1;
         chk("to_wait_mready", bus.m_ready, 0);
         chk("to_wait_err", bus.timeout_err, 0);
         chk("to_wait_svalid", bus.s_valid, 1);
      end
      tick;
      #1;
      chk("to_mready", bus.m_ready, 2'b01);
      chk("to_rdata", bus.m_rdata, 32'hdead_beef);
      chk("to_err", bus.timeout_err, 1);
      chk("to_svalid", bus.s_valid, 0);
      tick;
      bus.m_valid = 2'b00;
      #1;
      chk("to_done_err", bus.timeout_err, 0);
      chk("to_done_mready", bus.m_ready, 0);
      tick;
      // s_ready on the final watchdog cycle completes normally
      bus.m_valid = 2'b01;
      tick;
      for (int k = 0; k < 7; k++) tick;
      bus.s_ready = 1'b1;
      bus.s_rdata = 32'h55aa;
      #1;
      chk("tolast_mready", bus.m_ready, 2'b01);
      chk("tolast_rdata", bus.m_rdata, 32'h55aa);
      chk("tolast_err", bus.timeout_err, 0);
      tick;
      bus.s_ready = 1'b0;
      bus.m_valid = 2'b00;
      tick;
      // reset two cycles into a master 1 transaction
      bus.m_valid = 2'b10;
      tick;
      #1;
      chk("rs_grant_before", bus.grant_id, 1);
      tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      #1;
      chk("rs_svalid", bus.s_valid, 0);
      chk("rs_mready", bus.m_ready, 0);
      chk("rs_grant", bus.grant_id, 0);
      tick;
      #1;
      chk("rs_regrant", bus.grant_id, 1);
      chk("rs_regrant_svalid", bus.s_valid, 1);
      bus.s_ready = 1'b1;
      #1;
      chk("rs_mready", bus.m_ready, 2'b10);
      tick;
      bus.s_ready = 1'b0;
      bus.m_valid = 2'b00;
      tick;
      // granted master 0 abandons its request; pending master 1 goes next
      bus.m_valid = 2'b11;
      tick;
      #1;
      chk("dr_grant", bus.grant_id, 0);
      bus.m_valid = 2'b10;
      bus.s_ready = 1'b1;
      #1;
      chk("dr_svalid", bus.s_valid, 0);
      chk("dr_mready", bus.m_ready, 0);
      tick;
      bus.s_ready = 1'b0;
      #1;
      chk("dr_idle_svalid", bus.s_valid, 0);
      tick;
      #1;
      chk("dr_next_grant", bus.grant_id, 1);
      chk("dr_next_svalid", bus.s_valid, 1);
      bus.s_ready = 1'b1;
      #1;
      chk("dr_next_mready", bus.m_ready, 2'b10);
      tick;
      bus.s_ready = 1'b0;
      bus.m_valid = 2'b00;
      tick;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Round-robin arbiter sharing one picorv32-style valid/ready memory bus (local RAM + GPIO decoder) among NR_MASTERS requesters, e.g. CPU and a future DMA/debug master.
- Grants one whole transaction at a time, muxes address/data/strobes to the slave side, and routes ready back to the granted master.
- A watchdog terminates any transaction that receives no ready within TIMEOUT_CYCLES.

Parameters:
- NR_MASTERS, 2, number of requesters (2..8).
- TIMEOUT_CYCLES, 256, BUSY cycles without s_ready before forced termination; 0 disables the watchdog.
- ERR_RDATA, 32'hdead_beef, read data returned on timeout.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous active-high reset.
- m_valid  input  NR_MASTERS  per-master request.
- m_instr  input  NR_MASTERS  per-master instruction-fetch flag.
- m_addr  input  32*NR_MASTERS  packed addresses; master i at [32*i+:32].
- m_wdata  input  32*NR_MASTERS  packed write data.
- m_wstrb  input  4*NR_MASTERS  packed byte strobes; 0 means read.
- m_ready  output  NR_MASTERS  per-master completion pulse.
- m_rdata  output  32  read data broadcast to all masters; valid only with m_ready.
- s_valid  output  1  slave request.
- s_instr  output  1  granted master's instr flag.
- s_addr  output  32  granted address.
- s_wdata  output  32  granted write data.
- s_wstrb  output  4  granted strobes.
- s_ready  input  1  slave completion.
- s_rdata  input  32  slave read data.
- grant_id  output  $clog2(NR_MASTERS), min 1  index of the current/last granted master.
- timeout_err  output  1  one-cycle pulse on watchdog termination.

Behaviour:
- Clock and reset: one clock `clk`; synchronous, active-high `reset`.
- Reset values: FSM=IDLE, s_valid=0, m_ready=0, grant_id=0, timeout_err=0, rr_ptr=NR_MASTERS-1 (master 0 wins first), watchdog=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any m_valid is set, pick the first set bit scanning from rr_ptr+1 with wrap-around modulo NR_MASTERS.
  - Register the winner into grant_id and go to BUSY. This is one cycle of arbitration latency.
  - If no m_valid is set, stay in IDLE.
- BUSY:
  - s_valid=1; s_* fields are combinational muxes of the grant_id master's inputs.
  - When s_ready=1, assert m_ready[grant_id]=1 combinationally in the same cycle, m_rdata=s_rdata, rr_ptr<=grant_id, then go to DONE.
- DONE:
  - One dead cycle with s_valid=0 so the master can drop or refresh its valid and the slave's registered ready can clear.
  - Always go to IDLE.
- Minimum cost: 3 cycles per transaction with a single-cycle slave. Back-to-back requests from different masters alternate strictly.
- Watchdog:
  - The counter clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the count reaches TIMEOUT_CYCLES-1 with s_ready still 0: m_ready[grant_id]=1, m_rdata=ERR_RDATA, timeout_err=1, s_valid=0 that cycle, rr_ptr<=grant_id, go to DONE.
  - s_ready=1 on the terminating cycle takes precedence: normal completion, no error.
- Granted master drops m_valid while BUSY (protocol violation): s_valid=0 that cycle, no m_ready, rr_ptr unchanged, go to IDLE.
- Non-granted masters: m_ready stays 0 and their request fields are ignored. Only one m_ready bit is ever set, and never outside BUSY.
- m_rdata=0 whenever no m_ready is asserted (keeps the CPU X-check clean).
- Reset mid-transaction: next cycle is IDLE, s_valid=0, no m_ready pulse. Slave state is the slave's own concern.
- grant_id holds its value through DONE/IDLE until the next grant.

Decomposition:
- Shared package mem_bus_pkg:
  - FSM state encoding (IDLE=2'd0, BUSY=2'd1, DONE=2'd2).
  - Bus field widths (ADDR_W=32, DATA_W=32, STRB_W=4).
  - Default ERR_RDATA.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: winner index, any_req.
  - Unit-testable standalone.
- The top module holds the FSM, watchdog counter and muxes.

Test Plan:
- Single master 0 read at 0x100, slave returns ready 1 cycle after s_valid with rdata 0x12345678 -> grant after 1 cycle, m_ready[0] pulses once, m_rdata=0x12345678, DONE cycle has s_valid=0.
- Masters 0 and 1 hold continuous requests for 6 transactions -> grants ordered 0,1,0,1,0,1; never two m_ready bits set; the s_addr/s_wstrb of each request match its granted master.
- Master 1 writes wstrb=4'b0011, wdata=0xaabbccdd to 0x40 -> s_wstrb=4'b0011 and s_wdata=0xaabbccdd while BUSY; m_ready[1] only.
- TIMEOUT_CYCLES=8, slave never readies -> after 8 BUSY cycles: m_ready[0]=1, m_rdata=0xdeadbeef, timeout_err single pulse, then IDLE; s_ready on cycle 8 instead gives normal completion with no error.
- Reset asserted 2 cycles into BUSY -> next cycle s_valid=0, no m_ready, grant_id=0; a subsequent request from master 1 alone is granted normally.
- Granted master drops valid in BUSY -> s_valid falls the same cycle, no m_ready, the other pending master is granted next.
